// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a word-addressed register RAM, with independent write and read FSMs.
// Optional backpressure stress: define AXI_SLAVE_RAM_STALL_EN for LFSR-gated readies and R_VALID.

module axi_slave_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        SLAVE_CLK,
  input  logic        SLAVE_RSTN,
  input  logic [3:0]  SLAVE_WR_ADDR_ID,
  input  logic [31:0] SLAVE_WR_ADDR,
  input  logic [7:0]  SLAVE_WR_ADDR_LEN,
  input  logic [1:0]  SLAVE_WR_ADDR_BURST,
  input  logic        SLAVE_WR_ADDR_VALID,
  output logic        SLAVE_WR_ADDR_READY,
  input  logic [31:0] SLAVE_WR_DATA,
  input  logic [3:0]  SLAVE_WR_STRB,
  input  logic        SLAVE_WR_DATA_LAST,
  input  logic        SLAVE_WR_DATA_VALID,
  output logic        SLAVE_WR_DATA_READY,
  output logic [3:0]  SLAVE_WR_BACK_ID,
  output logic [1:0]  SLAVE_WR_BACK_RESP,
  output logic        SLAVE_WR_BACK_VALID,
  input  logic        SLAVE_WR_BACK_READY,
  input  logic [3:0]  SLAVE_RD_ADDR_ID,
  input  logic [31:0] SLAVE_RD_ADDR,
  input  logic [7:0]  SLAVE_RD_ADDR_LEN,
  input  logic [1:0]  SLAVE_RD_ADDR_BURST,
  input  logic        SLAVE_RD_ADDR_VALID,
  output logic        SLAVE_RD_ADDR_READY,
  output logic [3:0]  SLAVE_RD_BACK_ID,
  output logic [31:0] SLAVE_RD_DATA,
  output logic [1:0]  SLAVE_RD_DATA_RESP,
  output logic        SLAVE_RD_DATA_LAST,
  output logic        SLAVE_RD_DATA_VALID,
  input  logic        SLAVE_RD_DATA_READY
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  function automatic logic fIllegal(input logic [1:0] burst, input logic [7:0] len);
    fIllegal = (burst == 2'b11) ||
               ((burst == BURST_WRAP) &&
                !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // WRAP keeps the bits above the (LEN+1)*4-byte window and wraps the bits inside it.
  function automatic logic [31:0] fNextAddr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] mask;
    mask = {22'd0, len, 2'b11};
    case (burst)
      BURST_INCR: fNextAddr = addr + 32'd4;
      BURST_WRAP: fNextAddr = (addr & ~mask) | ((addr + 32'd4) & mask);
      default:    fNextAddr = addr;
    endcase
  endfunction

  function automatic logic fInRange(input logic [31:0] addr);
    fInRange = (addr - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] fIndex(input logic [31:0] addr);
    fIndex = AW'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [1:0] fWorst(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_SLVERR || b == RESP_SLVERR)      fWorst = RESP_SLVERR;
    else if (a == RESP_DECERR || b == RESP_DECERR) fWorst = RESP_DECERR;
    else                                           fWorst = RESP_OKAY;
  endfunction

  logic [31:0] r_mem [DEPTH];
  logic        w_stall;

`ifdef AXI_SLAVE_RAM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) r_lfsr <= 16'hACE1;
    else             r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // ---------------- write channel ----------------
  wstate_e     r_wState, w_wNext;
  logic [3:0]  r_wId;
  logic [31:0] r_wAddr;
  logic [7:0]  r_wLen;
  logic [7:0]  r_wBeat;
  logic [1:0]  r_wBurst;
  logic        r_wIllegal;
  logic [1:0]  r_wResp;
  logic        w_awReady, w_wReady, w_bValid;
  logic        w_awHs, w_wHs, w_wLastBeat, w_wInRange, w_memWe;
  logic [1:0]  w_wBeatResp;
  logic [AW-1:0] w_wIdx;

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) r_wState <= W_IDLE;
    else             r_wState <= w_wNext;
  end

  always_comb begin
    w_wNext   = r_wState;
    w_awReady = 1'b0;
    w_wReady  = 1'b0;
    w_bValid  = 1'b0;
    case (r_wState)
      W_IDLE: begin
        w_awReady = !w_stall;
        if (SLAVE_WR_ADDR_VALID && !w_stall) w_wNext = W_DATA;
      end
      W_DATA: begin
        w_wReady = !w_stall;
        if (SLAVE_WR_DATA_VALID && !w_stall && (r_wBeat == r_wLen)) w_wNext = W_RESP;
      end
      W_RESP: begin
        w_bValid = 1'b1;
        if (SLAVE_WR_BACK_READY) w_wNext = W_IDLE;
      end
      default: w_wNext = W_IDLE;
    endcase
  end

  assign w_awHs      = SLAVE_WR_ADDR_VALID && w_awReady;
  assign w_wHs       = SLAVE_WR_DATA_VALID && w_wReady;
  assign w_wLastBeat = (r_wBeat == r_wLen);
  assign w_wInRange  = fInRange(r_wAddr);
  assign w_wIdx      = fIndex(r_wAddr);
  assign w_memWe     = w_wHs && !r_wIllegal && w_wInRange;

  always_comb begin
    w_wBeatResp = RESP_OKAY;
    if (r_wIllegal || (SLAVE_WR_DATA_LAST != w_wLastBeat)) w_wBeatResp = RESP_SLVERR;
    else if (!w_wInRange)                                  w_wBeatResp = RESP_DECERR;
  end

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) begin
      r_wId      <= '0;
      r_wAddr    <= '0;
      r_wLen     <= '0;
      r_wBeat    <= '0;
      r_wBurst   <= '0;
      r_wIllegal <= 1'b0;
      r_wResp    <= RESP_OKAY;
    end else if (w_awHs) begin
      r_wId      <= SLAVE_WR_ADDR_ID;
      r_wAddr    <= SLAVE_WR_ADDR;
      r_wLen     <= SLAVE_WR_ADDR_LEN;
      r_wBeat    <= '0;
      r_wBurst   <= SLAVE_WR_ADDR_BURST;
      r_wIllegal <= fIllegal(SLAVE_WR_ADDR_BURST, SLAVE_WR_ADDR_LEN);
      r_wResp    <= RESP_OKAY;
    end else if (w_wHs) begin
      r_wAddr    <= fNextAddr(r_wAddr, r_wLen, r_wBurst);
      r_wBeat    <= r_wBeat + 8'd1;
      r_wResp    <= fWorst(r_wResp, w_wBeatResp);
    end
  end

  // RAM contents survive reset; only the FSM gating stops writes during it.
  always_ff @(posedge SLAVE_CLK) begin
    if (w_memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (SLAVE_WR_STRB[b]) r_mem[w_wIdx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
      end
    end
  end

  assign SLAVE_WR_ADDR_READY = w_awReady;
  assign SLAVE_WR_DATA_READY = w_wReady;
  assign SLAVE_WR_BACK_VALID = w_bValid;
  assign SLAVE_WR_BACK_ID    = r_wId;
  assign SLAVE_WR_BACK_RESP  = r_wResp;

  // ---------------- read channel ----------------
  rstate_e     r_rState, w_rNext;
  logic [3:0]  r_rId;
  logic [31:0] r_rAddr;
  logic [7:0]  r_rLen;
  logic [7:0]  r_rBeat;
  logic [1:0]  r_rBurst;
  logic        r_rIllegal;
  logic [31:0] r_rData;
  logic [1:0]  r_rResp;
  logic        r_rLast;
  logic        r_rValid;
  logic        w_arReady, w_arHs, w_rHs, w_rLoad;
  logic [31:0] w_rSelAddr, w_rSelData;
  logic [7:0]  w_rSelBeat, w_rSelLen;
  logic        w_rSelIllegal;
  logic [1:0]  w_rSelResp;

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) r_rState <= R_IDLE;
    else             r_rState <= w_rNext;
  end

  always_comb begin
    w_rNext   = r_rState;
    w_arReady = 1'b0;
    case (r_rState)
      R_IDLE: begin
        w_arReady = !w_stall;
        if (SLAVE_RD_ADDR_VALID && !w_stall) w_rNext = R_DATA;
      end
      R_DATA: begin
        if (r_rValid && SLAVE_RD_DATA_READY && r_rLast) w_rNext = R_IDLE;
      end
      default: w_rNext = R_IDLE;
    endcase
  end

  assign w_arHs  = SLAVE_RD_ADDR_VALID && w_arReady;
  assign w_rHs   = r_rValid && SLAVE_RD_DATA_READY;
  assign w_rLoad = w_arHs ||
                   ((r_rState == R_DATA) && (r_rValid ? (SLAVE_RD_DATA_READY && !r_rLast) : 1'b1));

  // Selects the beat to register next: the new burst, the following beat, or a pending reload.
  always_comb begin
    w_rSelAddr    = r_rAddr;
    w_rSelBeat    = r_rBeat;
    w_rSelLen     = r_rLen;
    w_rSelIllegal = r_rIllegal;
    if (r_rState == R_IDLE) begin
      w_rSelAddr    = SLAVE_RD_ADDR;
      w_rSelBeat    = 8'd0;
      w_rSelLen     = SLAVE_RD_ADDR_LEN;
      w_rSelIllegal = fIllegal(SLAVE_RD_ADDR_BURST, SLAVE_RD_ADDR_LEN);
    end else if (r_rValid) begin
      w_rSelAddr    = fNextAddr(r_rAddr, r_rLen, r_rBurst);
      w_rSelBeat    = r_rBeat + 8'd1;
    end
  end

  always_comb begin
    w_rSelData = '0;
    w_rSelResp = RESP_OKAY;
    if (w_rSelIllegal)              w_rSelResp = RESP_SLVERR;
    else if (!fInRange(w_rSelAddr)) w_rSelResp = RESP_DECERR;
    else                            w_rSelData = r_mem[fIndex(w_rSelAddr)];
  end

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) begin
      r_rId      <= '0;
      r_rLen     <= '0;
      r_rBurst   <= '0;
      r_rIllegal <= 1'b0;
    end else if (w_arHs) begin
      r_rId      <= SLAVE_RD_ADDR_ID;
      r_rLen     <= SLAVE_RD_ADDR_LEN;
      r_rBurst   <= SLAVE_RD_ADDR_BURST;
      r_rIllegal <= fIllegal(SLAVE_RD_ADDR_BURST, SLAVE_RD_ADDR_LEN);
    end
  end

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) begin
      r_rAddr  <= '0;
      r_rBeat  <= '0;
      r_rData  <= '0;
      r_rResp  <= RESP_OKAY;
      r_rLast  <= 1'b0;
      r_rValid <= 1'b0;
    end else if (w_rLoad) begin
      r_rAddr  <= w_rSelAddr;
      r_rBeat  <= w_rSelBeat;
      r_rData  <= w_rSelData;
      r_rResp  <= w_rSelResp;
      r_rLast  <= (w_rSelBeat == w_rSelLen);
      r_rValid <= !w_stall;
    end else if (w_rHs) begin
      r_rValid <= 1'b0;
    end
  end

  assign SLAVE_RD_ADDR_READY = w_arReady;
  assign SLAVE_RD_BACK_ID    = r_rId;
  assign SLAVE_RD_DATA       = r_rData;
  assign SLAVE_RD_DATA_RESP  = r_rResp;
  assign SLAVE_RD_DATA_LAST  = r_rLast;
  assign SLAVE_RD_DATA_VALID = r_rValid;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Randomized and directed bench for axi_slave_ram, checked against a behavioural memory model.

module tb_axi_slave_ram;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;
  localparam int          LIMIT = 200;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  awId;
  logic [31:0] awAddr;
  logic [7:0]  awLen;
  logic [1:0]  awBurst;
  logic        awValid, awReady;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wLast, wValid, wReady;
  logic [3:0]  bId;
  logic [1:0]  bResp;
  logic        bValid, bReady;
  logic [3:0]  arId;
  logic [31:0] arAddr;
  logic [7:0]  arLen;
  logic [1:0]  arBurst;
  logic        arValid, arReady;
  logic [3:0]  rId;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rLast, rValid, rReady;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] wrData [256];
  logic [3:0]  wrStrb [256];
  logic [31:0] rdData [256];
  logic [1:0]  rdResp [256];
  logic        rdLast [256];
  logic [3:0]  rdId   [256];
  int          rdCount;
  int          rdFirstWait;
  logic [3:0]  gotBid;
  logic [1:0]  gotBresp;

  axi_slave_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .SLAVE_CLK(clk), .SLAVE_RSTN(rstn),
    .SLAVE_WR_ADDR_ID(awId), .SLAVE_WR_ADDR(awAddr), .SLAVE_WR_ADDR_LEN(awLen),
    .SLAVE_WR_ADDR_BURST(awBurst), .SLAVE_WR_ADDR_VALID(awValid), .SLAVE_WR_ADDR_READY(awReady),
    .SLAVE_WR_DATA(wData), .SLAVE_WR_STRB(wStrb), .SLAVE_WR_DATA_LAST(wLast),
    .SLAVE_WR_DATA_VALID(wValid), .SLAVE_WR_DATA_READY(wReady),
    .SLAVE_WR_BACK_ID(bId), .SLAVE_WR_BACK_RESP(bResp), .SLAVE_WR_BACK_VALID(bValid),
    .SLAVE_WR_BACK_READY(bReady),
    .SLAVE_RD_ADDR_ID(arId), .SLAVE_RD_ADDR(arAddr), .SLAVE_RD_ADDR_LEN(arLen),
    .SLAVE_RD_ADDR_BURST(arBurst), .SLAVE_RD_ADDR_VALID(arValid), .SLAVE_RD_ADDR_READY(arReady),
    .SLAVE_RD_BACK_ID(rId), .SLAVE_RD_DATA(rData), .SLAVE_RD_DATA_RESP(rResp),
    .SLAVE_RD_DATA_LAST(rLast), .SLAVE_RD_DATA_VALID(rValid), .SLAVE_RD_DATA_READY(rReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: burst address sequence computed from window arithmetic.
  function automatic logic [31:0] refAddr(input logic [31:0] start, input int len,
                                          input logic [1:0] burst, input int i);
    longint bytes, base, off;
    case (burst)
      2'b00: return start;
      2'b01: return start + 32'(4 * i);
      default: begin
        bytes = longint'((len + 1) * 4);
        base  = longint'(start) - (longint'(start) % bytes);
        off   = longint'(start) - base;
        return 32'(base + ((off + 4 * i) % bytes));
      end
    endcase
  endfunction

  function automatic bit refLegal(input logic [1:0] burst, input int len);
    if (burst == 2'b11) return 1'b0;
    if (burst == 2'b10) return (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  function automatic bit refInRange(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int lastAt);
    int n;
    @(negedge clk);
    awId = id; awAddr = addr; awLen = 8'(len); awBurst = burst; awValid = 1'b1;
    n = 0;
    while (!awReady && n < LIMIT) begin @(negedge clk); n++; end
    if (n == LIMIT) checkOutput("aw_ready_wait", 32'(awReady), 32'd1);
    @(negedge clk);
    awValid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wData = wrData[i]; wStrb = wrStrb[i]; wLast = (i == lastAt); wValid = 1'b1;
      n = 0;
      while (!wReady && n < LIMIT) begin @(negedge clk); n++; end
      if (n == LIMIT) checkOutput("w_ready_wait", 32'(wReady), 32'd1);
      @(negedge clk);
    end
    wValid = 1'b0; wLast = 1'b0;
    bReady = 1'b1;
    n = 0;
    while (!bValid && n < LIMIT) begin @(negedge clk); n++; end
    if (n == LIMIT) checkOutput("b_valid_wait", 32'(bValid), 32'd1);
    gotBid = bId; gotBresp = bResp;
    @(negedge clk);
    bReady = 1'b0;
  endtask

  task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input logic [1:0] burst, input int stallBeat);
    int n;
    bit done, stalled;
    logic [31:0] snapData;
    logic [1:0]  snapResp;
    logic        snapLast;
    @(negedge clk);
    arId = id; arAddr = addr; arLen = 8'(len); arBurst = burst; arValid = 1'b1;
    n = 0;
    while (!arReady && n < LIMIT) begin @(negedge clk); n++; end
    if (n == LIMIT) checkOutput("ar_ready_wait", 32'(arReady), 32'd1);
    @(negedge clk);
    arValid = 1'b0;
    rReady = 1'b1; rdCount = 0; rdFirstWait = -1; done = 1'b0; stalled = 1'b0; n = 0;
    while (!done && n < 4 * LIMIT) begin
      if (rValid) begin
        if (rdFirstWait < 0) rdFirstWait = n;
        if (!stalled && rdCount == stallBeat) begin
          stalled = 1'b1; rReady = 1'b0;
          snapData = rData; snapResp = rResp; snapLast = rLast;
          repeat (5) begin
            @(negedge clk);
            checkOutput("r_stall_valid", 32'(rValid), 32'd1);
            checkOutput("r_stall_data", rData, snapData);
            checkOutput("r_stall_resp", 32'(rResp), 32'(snapResp));
            checkOutput("r_stall_last", 32'(rLast), 32'(snapLast));
          end
          rReady = 1'b1;
        end
        if (rdCount < 256) begin
          rdData[rdCount] = rData; rdResp[rdCount] = rResp;
          rdLast[rdCount] = rLast; rdId[rdCount] = rId;
        end
        rdCount++;
        if (rLast || rdCount > 256) done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    rReady = 1'b0;
    if (!done) checkOutput("r_last_wait", 32'(done), 32'd1);
  endtask

  task automatic runWrite(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int lastAt);
    logic [1:0]  expResp;
    logic [31:0] a;
    int          idx;
    expResp = 2'b00;
    if (!refLegal(burst, len) || lastAt != len) expResp = 2'b10;
    else for (int i = 0; i <= len; i++) if (!refInRange(refAddr(addr, len, burst, i))) expResp = 2'b11;
    doWrite(id, addr, len, burst, lastAt);
    checkOutput("b_id", 32'(gotBid), 32'(id));
    checkOutput("b_resp", 32'(gotBresp), 32'(expResp));
    if (refLegal(burst, len)) begin
      for (int i = 0; i <= len; i++) begin
        a = refAddr(addr, len, burst, i);
        if (refInRange(a)) begin
          idx = int'((a - BASE) >> 2);
          for (int b = 0; b < 4; b++)
            if (wrStrb[i][b]) refMem[idx][8*b +: 8] = wrData[i][8*b +: 8];
        end
      end
    end
  endtask

  task automatic runRead(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int stallBeat);
    logic [31:0] a, expData;
    logic [1:0]  expResp;
    doRead(id, addr, len, burst, stallBeat);
    checkOutput("r_beats", 32'(rdCount), 32'(len + 1));
    for (int i = 0; i <= len && i < rdCount; i++) begin
      a = refAddr(addr, len, burst, i);
      expData = 32'd0; expResp = 2'b00;
      if (!refLegal(burst, len))  expResp = 2'b10;
      else if (!refInRange(a))    expResp = 2'b11;
      else                        expData = refMem[int'((a - BASE) >> 2)];
      checkOutput("r_data", rdData[i], expData);
      checkOutput("r_resp", 32'(rdResp[i]), 32'(expResp));
      checkOutput("r_last", 32'(rdLast[i]), 32'(i == len));
      checkOutput("r_id", 32'(rdId[i]), 32'(id));
    end
  endtask

  // One random burst: mostly legal shapes, some reserved/illegal and out-of-range starts.
  task automatic applyStimulus();
    int          pick, len, lastAt, word, stallBeat;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] addr;
    pick = $urandom_range(0, 9);
    if (pick < 2)      burst = 2'b00;
    else if (pick < 7) burst = 2'b01;
    else if (pick < 9) burst = 2'b10;
    else               burst = 2'b11;
    len = $urandom_range(0, 7);
    if (burst == 2'b10) begin
      pick = $urandom_range(0, 4);
      len = (pick == 0) ? 1 : (pick == 1) ? 3 : (pick == 2) ? 7 : (pick == 3) ? 15 : $urandom_range(0, 15);
    end
    word = $urandom_range(0, 255);
    if ($urandom_range(0, 9) == 0) word = $urandom_range(250, 259);
    addr = BASE + 32'(word * 4);
    id = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 0) begin
      for (int i = 0; i <= len; i++) begin
        wrData[i] = $urandom;
        wrStrb[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      lastAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len + 1) : len;
      runWrite(id, addr, len, burst, lastAt);
    end else begin
      stallBeat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      runRead(id, addr, len, burst, stallBeat);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    awId = '0; awAddr = '0; awLen = '0; awBurst = '0; awValid = 1'b0;
    wData = '0; wStrb = '0; wLast = 1'b0; wValid = 1'b0; bReady = 1'b0;
    arId = '0; arAddr = '0; arLen = '0; arBurst = '0; arValid = 1'b0; rReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_aw_ready", 32'(awReady), 32'd1);
    checkOutput("rst_ar_ready", 32'(arReady), 32'd1);
    checkOutput("rst_w_ready", 32'(wReady), 32'd0);
    checkOutput("rst_b_valid", 32'(bValid), 32'd0);
    checkOutput("rst_r_valid", 32'(rValid), 32'd0);
    checkOutput("rst_r_data", rData, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 256; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'hF; end
    runWrite(4'd0, BASE, 255, 2'b01, 255);

    for (int i = 0; i < 4; i++) begin wrData[i] = 32'(i + 1); wrStrb[i] = 4'hF; end
    runWrite(4'd5, BASE + 32'h10, 3, 2'b01, 3);
    runRead(4'd6, BASE + 32'h10, 3, 2'b01, -1);
    checkOutput("r_first_latency", 32'(rdFirstWait), 32'd0);
    checkOutput("incr_beat3", rdData[3], 32'd4);

    wrData[0] = 32'hFFFF_FFFF; wrStrb[0] = 4'hF;
    runWrite(4'd1, BASE + 32'h40, 0, 2'b01, 0);
    wrData[0] = 32'h0000_0000; wrStrb[0] = 4'b0101;
    runWrite(4'd2, BASE + 32'h40, 0, 2'b01, 0);
    runRead(4'd3, BASE + 32'h40, 0, 2'b01, -1);
    checkOutput("strb_merge", rdData[0], 32'hFF00_FF00);

    for (int i = 0; i < 8; i++) begin wrData[i] = 32'(i); wrStrb[i] = 4'hF; end
    runWrite(4'd4, BASE, 7, 2'b01, 7);
    runRead(4'd7, BASE + 32'h18, 3, 2'b10, -1);
    checkOutput("wrap_b0", rdData[0], 32'd6);
    checkOutput("wrap_b2", rdData[2], 32'd4);

    for (int i = 0; i < 4; i++) begin wrData[i] = 32'hA5A5_0001 + 32'(i); wrStrb[i] = 4'hF; end
    runWrite(4'd8, BASE + 32'h3FC, 3, 2'b01, 3);
    runRead(4'd9, BASE + 32'h3FC, 1, 2'b01, -1);
    checkOutput("edge_b0_data", rdData[0], 32'hA5A5_0001);
    checkOutput("edge_b1_resp", 32'(rdResp[1]), 32'h3);

    for (int i = 0; i < 2; i++) begin wrData[i] = 32'h1234_5678; wrStrb[i] = 4'hF; end
    runWrite(4'd10, BASE + 32'h40, 1, 2'b11, 1);
    runRead(4'd11, BASE + 32'h40, 0, 2'b01, -1);
    checkOutput("reserved_no_write", rdData[0], 32'hFF00_FF00);
    runWrite(4'd12, BASE + 32'h48, 1, 2'b01, 0);

    runRead(4'd13, BASE, 7, 2'b01, 3);

    for (int k = 0; k < 60; k++) applyStimulus();

    // Reset in the middle of a pending read and a partially written burst.
    @(negedge clk);
    arId = 4'd1; arAddr = BASE + 32'h20; arLen = 8'd7; arBurst = 2'b01; arValid = 1'b1;
    n = 0;
    while (!arReady && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    arValid = 1'b0;
    awId = 4'd9; awAddr = BASE + 32'h80; awLen = 8'd3; awBurst = 2'b01; awValid = 1'b1;
    n = 0;
    while (!awReady && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    awValid = 1'b0;
    wData = 32'hDEAD_BEEF; wStrb = 4'hF; wLast = 1'b0; wValid = 1'b1;
    n = 0;
    while (!wReady && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    wValid = 1'b0;
    refMem[int'(32'h80 >> 2)] = 32'hDEAD_BEEF;
    checkOutput("pre_reset_r_valid", 32'(rValid), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("mid_reset_r_valid", 32'(rValid), 32'd0);
    checkOutput("mid_reset_b_valid", 32'(bValid), 32'd0);
    checkOutput("mid_reset_w_ready", 32'(wReady), 32'd0);
    checkOutput("mid_reset_aw_ready", 32'(awReady), 32'd1);
    checkOutput("mid_reset_ar_ready", 32'(arReady), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    bReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_reset_b_valid", 32'(bValid), 32'd0);
      checkOutput("post_reset_r_valid", 32'(rValid), 32'd0);
    end
    bReady = 1'b0;
    runRead(4'd2, BASE + 32'h80, 0, 2'b01, -1);
    checkOutput("reset_kept_beat", rdData[0], 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
